// File: rtl/barrel_pkg.sv
// ---------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the barrel rotate scheduler and its helpers.
//   DATA_W   : operand/result width of the shared rotator (fixed at 16)
//   AMT_W    : rotate-amount width (fixed at 4, i.e. modulo-16 rotation)
//   state_t  : scheduler FSM states
//   req_id_t : index of one of the two requesters
// ---------------------------------------------------------------------------
package barrel_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/barrel.sv
// ---------------------------------------------------------------------------
// barrel
// Combinational 16-bit rotate-right: o = a ror c.
// Ports:
//   a : operand
//   c : rotate amount (0..15)
//   o : rotated result
// ---------------------------------------------------------------------------
module barrel (
    input  logic [15:0] a,
    input  logic [3:0]  c,
    output logic [15:0] o
);

    logic [15:0] stage0;
    logic [15:0] stage1;
    logic [15:0] stage2;

    // Log-depth rotator: each stage rotates by a power of two when its amount bit is set.
    assign stage0 = c[0] ? {a[0],        a[15:1]}      : a;
    assign stage1 = c[1] ? {stage0[1:0], stage0[15:2]} : stage0;
    assign stage2 = c[2] ? {stage1[3:0], stage1[15:4]} : stage1;
    assign o      = c[3] ? {stage2[7:0], stage2[15:8]} : stage2;

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
// Ports:
//   req        : request vector, bit i from requester i
//   last_grant : index of the requester granted most recently
//   en         : arbitration allowed this cycle; no grant when low
//   gnt        : one-hot grant (or zero)
// ---------------------------------------------------------------------------
module rr_arb2
    import barrel_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the one that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/barrel_rot_sched.sv
// ---------------------------------------------------------------------------
// barrel_rot_sched
// Shares a single 16-bit barrel rotator between two requesters using
// round-robin arbitration, valid/ready handshakes and registered
// operands/result. One operation at a time: IDLE -> EXEC -> DONE -> IDLE.
//
// Optional feature macro: BARREL_ROT_SCHED_ROTL_EN
//   defined   : req_dir[i]=1 makes requester i rotate left
//   undefined : req_dir is ignored, every operation rotates right
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester operation valid
//   req_ready  : per-requester accept strobe (one-hot or zero, IDLE only)
//   req_data0  : requester 0 operand
//   req_amt0   : requester 0 rotate amount
//   req_data1  : requester 1 operand
//   req_amt1   : requester 1 rotate amount
//   req_dir    : per-requester rotate-left select
//   res_valid  : result register holds an unconsumed result
//   res_ready  : consumer accepts the result
//   res_data   : rotated result
//   res_id     : requester that issued the result
//   op_count   : results consumed since reset (wraps)
// ---------------------------------------------------------------------------
module barrel_rot_sched
    import barrel_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [AMT_W-1:0]  req_amt0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [AMT_W-1:0]  req_amt1,
    input  logic [1:0]        req_dir,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output req_id_t           res_id,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        gnt;
    req_id_t           last_grant;
    req_id_t           win_id;
    logic [DATA_W-1:0] win_data;
    logic [AMT_W-1:0]  win_amt;
    logic [AMT_W-1:0]  win_amt_eff;
    logic [DATA_W-1:0] op_data;
    logic [AMT_W-1:0]  op_amt;
    req_id_t           op_id;
    logic [DATA_W-1:0] rot_out;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .gnt        (gnt)
    );

    assign req_ready = gnt;
    assign win_id    = gnt[1];
    assign win_data  = win_id ? req_data1 : req_data0;
    assign win_amt   = win_id ? req_amt1  : req_amt0;

`ifdef BARREL_ROT_SCHED_ROTL_EN
    // The shared rotator only turns right, so a left rotate by n is stored as
    // a right rotate by (16-n) mod 16; the subtraction wraps naturally in AMT_W bits.
    assign win_amt_eff = req_dir[win_id] ? (AMT_W'(0) - win_amt) : win_amt;
`else
    // Direction input is accepted but has no effect in this build.
    logic unused_dir;
    assign unused_dir  = ^req_dir;
    assign win_amt_eff = win_amt;
`endif

    barrel u_barrel (
        .a (op_data),
        .c (op_amt),
        .o (rot_out)
    );

    // Next-state logic: leave IDLE only on a grant, leave DONE only when the result is taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt != 2'b00) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand capture and result registers. Reset starts with last_grant=1
    // so that requester 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_data    <= '0;
            op_amt     <= '0;
            op_id      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        op_data    <= win_data;
                        op_amt     <= win_amt_eff;
                        op_id      <= win_id;
                        last_grant <= win_id;
                    end
                end
                EXEC: begin
                    res_data  <= rot_out;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_rot_sched.sv
// ---------------------------------------------------------------------------
// tb_barrel_rot_sched
// Self-checking bench for barrel_rot_sched. A second instance with a 3-bit
// counter shares all inputs so the counter wrap is observed within a short run.
// ---------------------------------------------------------------------------
module tb_barrel_rot_sched;

`ifdef BARREL_ROT_SCHED_ROTL_EN
    localparam bit ROTL = 1'b1;
`else
    localparam bit ROTL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_dir;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [3:0]  req_amt0;
    logic [3:0]  req_amt1;
    logic        res_ready;

    logic [1:0]  req_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_id;
    logic [15:0] op_count;

    logic [1:0]  req_ready_w;
    logic        res_valid_w;
    logic [15:0] res_data_w;
    logic        res_id_w;
    logic [2:0]  op_count_w;

    int checks = 0;
    int errors = 0;
    int lastGrant = 1;
    int consumed = 0;

    always #5 clk = ~clk;

    barrel_rot_sched #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_amt0  (req_amt0),
        .req_data1 (req_data1),
        .req_amt1  (req_amt1),
        .req_dir   (req_dir),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    barrel_rot_sched #(.CNT_W(3)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready_w),
        .req_data0 (req_data0),
        .req_amt0  (req_amt0),
        .req_data1 (req_data1),
        .req_amt1  (req_amt1),
        .req_dir   (req_dir),
        .res_valid (res_valid_w),
        .res_ready (res_ready),
        .res_data  (res_data_w),
        .res_id    (res_id_w),
        .op_count  (op_count_w)
    );

    // Reference rotation straight from the definition: right via a doubled word shifted down,
    // left via a doubled word shifted up.
    function automatic logic [15:0] rotRef(input logic [15:0] d, input int n, input bit left);
        logic [31:0] x;
        logic [31:0] y;
        x = {d, d};
        if (left) begin
            y = x << (n % 16);
            return y[31:16];
        end
        y = x >> (n % 16);
        return y[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d0, input logic [3:0] a0,
                                 input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] dir);
        req_valid = v;
        req_data0 = d0;
        req_amt0  = a0;
        req_data1 = d1;
        req_amt1  = a1;
        req_dir   = dir;
    endtask

    // One complete transaction starting in IDLE just after a clock edge.
    task automatic runOp(input logic [1:0] v, input logic [15:0] d0, input logic [3:0] a0,
                         input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] dir,
                         input int holdCycles);
        int w;
        logic [15:0] expData;
        w = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : ((lastGrant == 1) ? 0 : 1);
        expData = (w == 0) ? rotRef(d0, a0, ROTL && dir[0]) : rotRef(d1, a1, ROTL && dir[1]);

        applyStimulus(v, d0, a0, d1, a1, dir);
        #1;
        checkOutput("req_ready_idle", {30'd0, req_ready}, 32'd1 << w);

        @(posedge clk); #1;
        lastGrant = w;
        checkOutput("req_ready_exec", {30'd0, req_ready}, 32'd0);
        checkOutput("res_valid_exec", {31'd0, res_valid}, 32'd0);
        applyStimulus(2'($urandom_range(1, 3)), 16'($urandom), 4'($urandom),
                      16'($urandom), 4'($urandom), 2'($urandom));
        #1;
        checkOutput("req_ready_exec_busy", {30'd0, req_ready}, 32'd0);

        @(posedge clk); #1;
        checkOutput("res_valid_done", {31'd0, res_valid}, 32'd1);
        checkOutput("res_data", {16'd0, res_data}, {16'd0, expData});
        checkOutput("res_id", {31'd0, res_id}, w);
        checkOutput("req_ready_done", {30'd0, req_ready}, 32'd0);

        res_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("hold_data", {16'd0, res_data}, {16'd0, expData});
            checkOutput("hold_id", {31'd0, res_id}, w);
            checkOutput("hold_ready", {30'd0, req_ready}, 32'd0);
            checkOutput("hold_count", {16'd0, op_count}, consumed % 65536);
        end

        applyStimulus(2'b00, 16'd0, 4'd0, 16'd0, 4'd0, 2'b00);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        consumed++;
        checkOutput("res_valid_consumed", {31'd0, res_valid}, 32'd0);
        checkOutput("op_count", {16'd0, op_count}, consumed % 65536);
        checkOutput("op_count_narrow", {29'd0, op_count_w}, consumed % 8);
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        applyStimulus(2'b00, 16'd0, 4'd0, 16'd0, 4'd0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset_res_data", {16'd0, res_data}, 32'd0);
        checkOutput("reset_res_id", {31'd0, res_id}, 32'd0);
        checkOutput("reset_op_count", {16'd0, op_count}, 32'd0);
        rst = 1'b0;

        // Accept an operation, then abort it with reset while in EXEC.
        @(posedge clk); #1;
        applyStimulus(2'b01, 16'h1234, 4'd4, 16'd0, 4'd0, 2'b00);
        #1;
        checkOutput("abort_accept", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(2'b00, 16'd0, 4'd0, 16'd0, 4'd0, 2'b00);
        rst = 1'b1;
        #1;
        checkOutput("abort_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("abort_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("abort_op_count", {16'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_never_reported", {31'd0, res_valid}, 32'd0);
        lastGrant = 1;
        @(posedge clk); #1;
        checkOutput("abort_still_idle", {31'd0, res_valid}, 32'd0);

        // Simultaneous requests straight after reset: id0, id1, then id0 again.
        runOp(2'b11, 16'h0001, 4'd1, 16'h8000, 4'd15, 2'b00, 0);
        runOp(2'b11, 16'h0001, 4'd1, 16'h8000, 4'd15, 2'b00, 0);
        runOp(2'b11, 16'h0001, 4'd1, 16'h8000, 4'd15, 2'b00, 0);

        // Directed single-requester cases, including the held-result case.
        runOp(2'b01, 16'h1234, 4'd4, 16'hFFFF, 4'd3, 2'b01, 0);
        runOp(2'b01, 16'h1234, 4'd4, 16'hFFFF, 4'd3, 2'b00, 0);
        runOp(2'b10, 16'h5555, 4'd7, 16'hA5C3, 4'd0, 2'b00, 0);
        runOp(2'b10, 16'h0000, 4'd0, 16'h8001, 4'd15, 2'b10, 0);
        runOp(2'b01, 16'hBEEF, 4'd8, 16'h0000, 4'd0, 2'b00, 5);

        // Randomized operations with random contention, direction and back-pressure.
        for (int n = 0; n < 250; n++) begin
            runOp(2'($urandom_range(1, 3)), 16'($urandom), 4'($urandom),
                  16'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
